// File: rtl/snn_spike_decoder.sv
// snn_spike_decoder
// Counts spikes per output neuron over a fixed observation window, then
// scans the counts one neuron per cycle to find the winning class.
// Reports the winner index, its count and a tie flag with a one-cycle pulse.
// Per-neuron counts stay readable through rd_sel/rd_count for host readout.
//
// Handshake: start is a request that is taken only on an edge where busy=0
// (busy = FSM not in IDLE); a start seen while busy=1 is dropped with no side
// effects. class_valid is a one-cycle strobe with no back-pressure: the
// class_* outputs change only in that cycle and hold until the next strobe.
// busy is already low in the strobe cycle, so a start there is accepted.

module snn_spike_decoder #(
    parameter int NUM_OUT = 8,
    parameter int WINDOW  = 256,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_OUT-1:0] out_spk,
    input  logic               start,
    output logic               busy,
    output logic               class_valid,
    output logic [IDX_W-1:0]   class_idx,
    output logic [CNT_W-1:0]   class_count,
    output logic               class_tie,
    input  logic [IDX_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_count,
    output logic [1:0]         dbg_state
);

    localparam int WC_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WC_W-1:0]  win_cnt_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic [CNT_W-1:0] cnt_q [NUM_OUT];

    // Running argmax held across the scan
    logic [CNT_W-1:0] best_q;
    logic [IDX_W-1:0] best_idx_q;
    logic             best_tie_q;

    // Argmax after folding in the neuron currently addressed by scan_idx_q
    logic [CNT_W-1:0] step_best;
    logic [IDX_W-1:0] step_idx;
    logic             step_tie;
    logic [CNT_W-1:0] cur_cnt;

    logic start_ok;
    logic win_last;
    logic scan_last;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign win_last  = (win_cnt_q == WC_W'(WINDOW - 1));
    assign scan_last = (scan_idx_q == IDX_W'(NUM_OUT - 1));

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ACCUM on start, ACCUM -> SCAN after WINDOW
    // samples, SCAN -> IDLE after the last neuron has been compared
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (win_last) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window sample counter and scan pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_q  <= '0;
            scan_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        win_cnt_q  <= '0;
                        scan_idx_q <= '0;
                    end
                end
                ST_ACCUM: begin
                    win_cnt_q  <= win_cnt_q + WC_W'(1);
                    scan_idx_q <= '0;
                end
                ST_SCAN: begin
                    scan_idx_q <= scan_last ? '0 : scan_idx_q + IDX_W'(1);
                end
                default: begin
                    win_cnt_q  <= '0;
                    scan_idx_q <= '0;
                end
            endcase
        end
    end

    // Per-neuron saturating spike counters; cleared on an accepted start,
    // frozen outside ACCUM so the scan and host readout see stable values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (start_ok) begin
                    cnt_q[i] <= '0;
                end else if ((state_q == ST_ACCUM) && out_spk[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // One argmax step: neuron 0 seeds the search, a strictly larger count
    // takes over, an equal count only raises the tie flag (lowest index wins)
    always_comb begin
        cur_cnt   = cnt_q[scan_idx_q];
        step_best = best_q;
        step_idx  = best_idx_q;
        step_tie  = best_tie_q;
        if (scan_idx_q == '0) begin
            step_best = cur_cnt;
            step_idx  = '0;
            step_tie  = 1'b0;
        end else if (cur_cnt > best_q) begin
            step_best = cur_cnt;
            step_idx  = scan_idx_q;
            step_tie  = 1'b0;
        end else if (cur_cnt == best_q) begin
            step_tie  = 1'b1;
        end
    end

    // Running argmax registers, advanced once per SCAN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q     <= '0;
            best_idx_q <= '0;
            best_tie_q <= 1'b0;
        end else if (state_q == ST_SCAN) begin
            best_q     <= step_best;
            best_idx_q <= step_idx;
            best_tie_q <= step_tie;
        end
    end

    // Result registers: loaded with the final step on the last scan edge,
    // together with the one-cycle class_valid strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_count <= '0;
            class_tie   <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if ((state_q == ST_SCAN) && scan_last) begin
                class_valid <= 1'b1;
                class_idx   <= step_idx;
                class_count <= step_best;
                class_tie   <= step_tie;
            end
        end
    end

    // Host readout of a live counter; out-of-range selects read as zero
    always_comb begin
        rd_count = '0;
        if ({{(32-IDX_W){1'b0}}, rd_sel} < 32'(NUM_OUT)) begin
            rd_count = cnt_q[rd_sel];
        end
    end

endmodule
